// File: rtl/icache_lite_pkg.sv
// Shared types and address helpers for the direct-mapped instruction cache.
// Holds the FSM encoding and default geometry.
package icache_lite_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_REFILL_REQ,
      ST_REFILL_DATA,
      ST_RESPOND
   } state_t;

   localparam int NUM_LINES_DEF  = 64;
   localparam int LINE_WORDS_DEF = 8;
   localparam int OFFW = $clog2(LINE_WORDS_DEF);
   localparam int IDXW = $clog2(NUM_LINES_DEF);
   localparam int TAGW = 32 - 2 - OFFW - IDXW;

   function automatic logic [31:0] line_base(
      input logic [31:0] pc,
      input int          offw
   );
      return (pc >> (offw + 2)) << (offw + 2);
   endfunction

   function automatic logic priv_fault(
      input logic        chk,
      input logic [1:0]  priv,
      input logic [31:0] pc,
      input logic [31:0] top
   );
      return chk && (priv == 2'd0) && (pc >= top);
   endfunction

endpackage

// File: rtl/icache_lite_ram.sv
// Synchronous-read, single-write-port storage array.
// Used for both the instruction words and the line tags.
module icache_lite_ram
   import icache_lite_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 512,
   parameter int AW    = 9
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/icache_lite.sv
// Direct-mapped read-only instruction cache, one request in flight,
// whole-line burst refill with critical-word capture.
module icache_lite
   import icache_lite_pkg::*;
#(
   parameter int          NUM_LINES          = NUM_LINES_DEF,
   parameter int          LINE_WORDS         = LINE_WORDS_DEF,
   parameter bit          SUPPORT_PRIV_CHECK = 1'b1,
   parameter logic [31:0] USER_TOP           = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_rd_i,
   input  logic        req_flush_i,
   input  logic        req_invalidate_i,
   input  logic [31:0] req_pc_i,
   input  logic [1:0]  req_priv_i,
   output logic        req_accept_o,
   output logic        resp_valid_o,
   output logic [31:0] resp_inst_o,
   output logic        resp_error_o,
   output logic        resp_page_fault_o,
   output logic        mem_rd_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_len_o,
   input  logic        mem_accept_i,
   input  logic        mem_valid_i,
   input  logic [31:0] mem_data_i,
   input  logic        mem_error_i,
   input  logic        mem_last_i
);

   localparam int OW = $clog2(LINE_WORDS);
   localparam int IW = $clog2(NUM_LINES);
   localparam int TW = 32 - 2 - OW - IW;
   localparam int AW = IW + OW;
   localparam logic [OW-1:0] LAST = OW'(LINE_WORDS - 1);

   state_t               state;
   logic [31:0]          pc_q;
   logic [1:0]           priv_q;
   logic [NUM_LINES-1:0] valid_q;
   logic [OW-1:0]        cnt_q;
   logic [31:0]          crit_q;
   logic                 err_q;
   logic                 flush_pend_q;

   logic [TW-1:0] tag_rd;
   logic [31:0]   data_rd;
   logic [IW-1:0] req_idx;
   logic [OW-1:0] req_off;
   logic [IW-1:0] idx_q;
   logic [OW-1:0] off_q;
   logic [TW-1:0] tag_q;

   logic lookup;
   logic fault;
   logic hit;
   logic beat;
   logic last_beat;
   logic beat_err;
   logic take_rd;
   logic to_idle;

   assign req_idx = req_pc_i[2+OW +: IW];
   assign req_off = req_pc_i[2 +: OW];
   assign idx_q   = pc_q[2+OW +: IW];
   assign off_q   = pc_q[2 +: OW];
   assign tag_q   = pc_q[31 -: TW];

   assign lookup = state == ST_LOOKUP;
   assign fault  = priv_fault(SUPPORT_PRIV_CHECK, priv_q, pc_q, USER_TOP);
   assign hit    = lookup && !fault && valid_q[idx_q] && (tag_rd == tag_q);

   assign beat      = (state == ST_REFILL_DATA) && mem_valid_i;
   assign last_beat = beat && (mem_last_i || cnt_q == LAST);
   // A last beat arriving before the line is full is treated as a bus error.
   assign beat_err  = err_q || mem_error_i ||
                      (mem_last_i && cnt_q != LAST);

   assign take_rd = req_accept_o && req_rd_i;
   assign to_idle = (lookup && (fault || (hit && !take_rd))) ||
                    (state == ST_RESPOND);

   icache_lite_ram #(
      .WIDTH (32),
      .DEPTH (NUM_LINES * LINE_WORDS),
      .AW    (AW)
   ) u_data (
      .clk   (clk),
      .we    (beat),
      .waddr ({idx_q, cnt_q}),
      .wdata (mem_data_i),
      .raddr ({req_idx, req_off}),
      .rdata (data_rd)
   );

   icache_lite_ram #(
      .WIDTH (TW),
      .DEPTH (NUM_LINES),
      .AW    (IW)
   ) u_tag (
      .clk   (clk),
      .we    (last_beat),
      .waddr (idx_q),
      .wdata (tag_q),
      .raddr (req_idx),
      .rdata (tag_rd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         pc_q         <= '0;
         priv_q       <= '0;
         valid_q      <= '0;
         cnt_q        <= '0;
         crit_q       <= '0;
         err_q        <= 1'b0;
         flush_pend_q <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (req_flush_i) begin
                  valid_q <= '0;
               end else if (req_invalidate_i) begin
                  valid_q[req_idx] <= 1'b0;
               end else if (req_rd_i) begin
                  pc_q   <= req_pc_i;
                  priv_q <= req_priv_i;
                  state  <= ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               if (req_flush_i)
                  flush_pend_q <= 1'b1;
               if (fault) begin
                  state <= ST_IDLE;
               end else if (!hit) begin
                  state <= ST_REFILL_REQ;
               end else if (take_rd) begin
                  pc_q   <= req_pc_i;
                  priv_q <= req_priv_i;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_REFILL_REQ: begin
               if (req_flush_i)
                  flush_pend_q <= 1'b1;
               if (mem_accept_i) begin
                  cnt_q <= '0;
                  state <= ST_REFILL_DATA;
               end
            end
            ST_REFILL_DATA: begin
               if (req_flush_i)
                  flush_pend_q <= 1'b1;
               if (mem_valid_i) begin
                  cnt_q <= cnt_q + OW'(1);
                  if (cnt_q == off_q)
                     crit_q <= mem_data_i;
                  if (mem_error_i)
                     err_q <= 1'b1;
                  if (last_beat) begin
                     valid_q[idx_q] <= !beat_err;
                     err_q          <= beat_err;
                     cnt_q          <= '0;
                     state          <= ST_RESPOND;
                  end
               end
            end
            ST_RESPOND: begin
               if (req_flush_i)
                  flush_pend_q <= 1'b1;
               err_q <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
         // Deferred flush lands after any refilled line was written.
         if (to_idle && (flush_pend_q || req_flush_i)) begin
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
         end
      end
   end

   assign req_accept_o = ((state == ST_IDLE) && !req_flush_i) ||
                         (hit && !flush_pend_q);

   assign resp_valid_o = (lookup && (fault || hit)) ||
                         (state == ST_RESPOND);

   assign resp_inst_o = hit                   ? data_rd :
                        (state == ST_RESPOND) ? crit_q  : 32'd0;

   assign resp_error_o      = (state == ST_RESPOND) && err_q;
   assign resp_page_fault_o = lookup && fault;

   assign mem_rd_o   = state == ST_REFILL_REQ;
   assign mem_addr_o = mem_rd_o ? line_base(pc_q, OW) : 32'd0;
   assign mem_len_o  = mem_rd_o ? 4'(LINE_WORDS - 1) : 4'd0;

endmodule

// File: tb/tb_icache_lite.sv
// Randomized bench for icache_lite with a line-level cache model
// and a behavioural burst memory.
module tb_icache_lite;
   import icache_lite_pkg::*;

   localparam int NL = NUM_LINES_DEF;
   localparam int LW = LINE_WORDS_DEF;
   localparam int LB = 1 << (OFFW + 2);

   logic        clk;
   logic        rst;
   logic        req_rd_i;
   logic        req_flush_i;
   logic        req_invalidate_i;
   logic [31:0] req_pc_i;
   logic [1:0]  req_priv_i;
   logic        req_accept_o;
   logic        resp_valid_o;
   logic [31:0] resp_inst_o;
   logic        resp_error_o;
   logic        resp_page_fault_o;
   logic        mem_rd_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_len_o;
   logic        mem_accept_i;
   logic        mem_valid_i;
   logic [31:0] mem_data_i;
   logic        mem_error_i;
   logic        mem_last_i;

   int n_cmp = 0;
   int n_bad = 0;

   bit            m_valid [NL];
   logic [TAGW-1:0] m_tag [NL];

   icache_lite dut (
      .clk               (clk),
      .rst               (rst),
      .req_rd_i          (req_rd_i),
      .req_flush_i       (req_flush_i),
      .req_invalidate_i  (req_invalidate_i),
      .req_pc_i          (req_pc_i),
      .req_priv_i        (req_priv_i),
      .req_accept_o      (req_accept_o),
      .resp_valid_o      (resp_valid_o),
      .resp_inst_o       (resp_inst_o),
      .resp_error_o      (resp_error_o),
      .resp_page_fault_o (resp_page_fault_o),
      .mem_rd_o          (mem_rd_o),
      .mem_addr_o        (mem_addr_o),
      .mem_len_o         (mem_len_o),
      .mem_accept_i      (mem_accept_i),
      .mem_valid_i       (mem_valid_i),
      .mem_data_i        (mem_data_i),
      .mem_error_i       (mem_error_i),
      .mem_last_i        (mem_last_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return 32'h1000 + ((a - 32'h100) >> 2);
   endfunction

   function automatic int line_idx(input logic [31:0] pc);
      return int'((pc / LB) % NL);
   endfunction

   function automatic logic [TAGW-1:0] line_tag(input logic [31:0] pc);
      return TAGW'(pc / (LB * NL));
   endfunction

   task automatic clear_model();
      for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] pc, input logic [1:0] pv,
                        input int eb, input bit early, input bit fl);
      bit fault, hit, xerr;
      int n, nb, idx;
      logic [31:0] base, word;
      fault = (pv == 2'd0) && (pc >= 32'h8000_0000);
      idx   = line_idx(pc);
      hit   = !fault && m_valid[idx] && (m_tag[idx] == line_tag(pc));
      base  = pc - (pc % LB);
      word  = pc - (pc % 4);
      nb    = early ? LW / 2 : LW;
      xerr  = early || (eb >= 0 && eb < nb);
      @(negedge clk);
      req_rd_i = 1; req_pc_i = pc; req_priv_i = pv;
      #1 check("accept", 32'(req_accept_o), 1);
      @(negedge clk);
      req_rd_i = 0;
      #1;
      if (fault || hit) begin
         check("lk_valid", 32'(resp_valid_o), 1);
         check("lk_inst", resp_inst_o, fault ? 32'd0 : mem_fn(word));
         check("lk_pf", 32'(resp_page_fault_o), 32'(fault));
         check("lk_err", 32'(resp_error_o), 0);
         @(negedge clk);
         #1 check("lk_pulse", 32'(resp_valid_o), 0);
         check("lk_nomem", 32'(mem_rd_o), 0);
         return;
      end
      check("miss_quiet", 32'(resp_valid_o), 0);
      n = 0;
      while (!mem_rd_o && n < 8) begin
         @(negedge clk); #1; n++;
      end
      check("mem_rd", 32'(mem_rd_o), 1);
      check("mem_addr", mem_addr_o, base);
      check("mem_len", 32'(mem_len_o), LW - 1);
      repeat ($urandom_range(0, 2)) begin
         @(negedge clk);
         #1 check("mem_hold", 32'(mem_rd_o), 1);
      end
      mem_accept_i = 1;
      @(negedge clk);
      mem_accept_i = 0;
      for (int i = 0; i < nb; i++) begin
         repeat ($urandom_range(0, 1)) @(negedge clk);
         mem_valid_i = 1;
         mem_data_i  = mem_fn(base + 32'(i) * 4);
         mem_error_i = (i == eb);
         mem_last_i  = (i == nb - 1);
         req_flush_i = fl && (i == 1);
         @(negedge clk);
         mem_valid_i = 0; mem_error_i = 0;
         mem_last_i  = 0; req_flush_i = 0;
      end
      #1;
      n = 0;
      while (!resp_valid_o && n < 8) begin
         @(negedge clk); #1; n++;
      end
      check("rsp_valid", 32'(resp_valid_o), 1);
      if (!xerr) check("rsp_inst", resp_inst_o, mem_fn(word));
      check("rsp_err", 32'(resp_error_o), 32'(xerr));
      check("rsp_pf", 32'(resp_page_fault_o), 0);
      @(negedge clk);
      #1 check("rsp_pulse", 32'(resp_valid_o), 0);
      if (fl) clear_model();
      m_tag[idx]   = line_tag(pc);
      m_valid[idx] = !xerr && !fl;
   endtask

   task automatic idle_flush(input logic [31:0] pc);
      @(negedge clk);
      req_flush_i = 1; req_rd_i = 1; req_pc_i = pc; req_priv_i = 2'd3;
      #1 check("fl_accept", 32'(req_accept_o), 0);
      @(negedge clk);
      req_flush_i = 0; req_rd_i = 0;
      #1 check("fl_noresp", 32'(resp_valid_o), 0);
      check("fl_idle", 32'(req_accept_o), 1);
      clear_model();
   endtask

   task automatic invalidate(input logic [31:0] pc);
      @(negedge clk);
      req_invalidate_i = 1; req_pc_i = pc;
      #1 check("inv_accept", 32'(req_accept_o), 1);
      @(negedge clk);
      req_invalidate_i = 0;
      #1 check("inv_noresp", 32'(resp_valid_o), 0);
      m_valid[line_idx(pc)] = 1'b0;
   endtask

   task automatic hit_burst(input logic [31:0] p0, input logic [31:0] p1,
                            input logic [31:0] p2);
      logic [31:0] ps [3];
      ps[0] = p0; ps[1] = p1; ps[2] = p2;
      @(negedge clk);
      req_rd_i = 1; req_pc_i = ps[0]; req_priv_i = 2'd3;
      #1 check("bb_acc0", 32'(req_accept_o), 1);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k < 3) req_pc_i = ps[k];
         else req_rd_i = 0;
         #1 check("bb_valid", 32'(resp_valid_o), 1);
         check("bb_inst", resp_inst_o, mem_fn(ps[k-1]));
         check("bb_nomem", 32'(mem_rd_o), 0);
         if (k < 3) check("bb_acc", 32'(req_accept_o), 1);
      end
      @(negedge clk);
      #1 check("bb_end", 32'(resp_valid_o), 0);
   endtask

   initial begin
      int n;
      logic [31:0] pc;
      rst = 1; req_rd_i = 0; req_flush_i = 0; req_invalidate_i = 0;
      req_pc_i = 0; req_priv_i = 0; mem_accept_i = 0; mem_valid_i = 0;
      mem_data_i = 0; mem_error_i = 0; mem_last_i = 0;
      clear_model();
      #12;
      check("rst_accept", 32'(req_accept_o), 1);
      check("rst_valid", 32'(resp_valid_o), 0);
      check("rst_inst", resp_inst_o, 0);
      check("rst_memrd", 32'(mem_rd_o), 0);
      check("rst_addr", mem_addr_o, 0);
      check("rst_len", 32'(mem_len_o), 0);
      @(negedge clk);
      rst = 0;

      fetch(32'h100, 2'd3, -1, 0, 0);
      fetch(32'h104, 2'd3, -1, 0, 0);
      hit_burst(32'h100, 32'h104, 32'h108);
      invalidate(32'h100);
      fetch(32'h11C, 2'd3, 7, 0, 0);
      fetch(32'h11C, 2'd3, -1, 0, 0);
      fetch(32'h8000_0000, 2'd0, -1, 0, 0);
      fetch(32'h8000_0000, 2'd3, -1, 0, 0);
      fetch(32'h200, 2'd3, -1, 0, 1);
      fetch(32'h200, 2'd3, -1, 0, 0);
      idle_flush(32'h200);
      fetch(32'h200, 2'd3, -1, 0, 0);
      fetch(32'h000, 2'd3, -1, 0, 0);
      fetch(32'(NL * LB), 2'd3, -1, 0, 0);
      fetch(32'h000, 2'd3, -1, 0, 0);
      fetch(32'h304, 2'd3, -1, 1, 0);
      fetch(32'h304, 2'd3, -1, 0, 0);

      @(negedge clk);
      req_rd_i = 1; req_pc_i = 32'h400; req_priv_i = 2'd3;
      @(negedge clk);
      req_rd_i = 0;
      #1 n = 0;
      while (!mem_rd_o && n < 8) begin
         @(negedge clk); #1; n++;
      end
      check("mr_memrd", 32'(mem_rd_o), 1);
      mem_accept_i = 1;
      @(negedge clk);
      mem_accept_i = 0; mem_valid_i = 1; mem_data_i = 32'hDEAD_BEEF;
      @(negedge clk);
      rst = 1; mem_valid_i = 0;
      #1 check("mr_accept", 32'(req_accept_o), 1);
      check("mr_valid", 32'(resp_valid_o), 0);
      check("mr_memrd0", 32'(mem_rd_o), 0);
      @(negedge clk);
      rst = 0;
      clear_model();
      fetch(32'h100, 2'd3, -1, 0, 0);

      for (int it = 0; it < 150; it++) begin
         int r;
         r  = int'($urandom_range(0, 19));
         pc = 32'($urandom_range(0, 2) * NL * LB) +
              32'($urandom_range(0, 3) * LB) +
              32'($urandom_range(0, 4 * LW - 1));
         if ($urandom_range(0, 5) == 0) pc = pc | 32'h8000_0000;
         if (r == 0) idle_flush(pc);
         else if (r == 1) invalidate(pc);
         else fetch(pc, 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 9) == 0) ?
                       int'($urandom_range(0, LW - 1)) : -1,
                    $urandom_range(0, 14) == 0,
                    $urandom_range(0, 14) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
